// File: rtl/sa_operand_sequencer.sv
// sa_operand_sequencer: fetches NxN weight rows or diagonally skewed feature vectors from operand memory
module sa_operand_sequencer #(
  parameter int ARRAY_DIM = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int LEN_W = 8,
  localparam int IW = $clog2(ARRAY_DIM) > 1 ? $clog2(ARRAY_DIM) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wl_start,
  input  logic                        fl_start,
  input  logic [ADDR_W-1:0]           weight_baseaddr,
  input  logic [ADDR_W-1:0]           feature_baseaddr,
  input  logic [LEN_W-1:0]            fl_len,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [ARRAY_DIM*DATA_W-1:0] mem_rd_data,
  output logic                        w_row_valid,
  output logic [IW-1:0]               w_row_idx,
  output logic [ARRAY_DIM*DATA_W-1:0] w_row_data,
  output logic [ARRAY_DIM-1:0]        a_valid,
  output logic [ARRAY_DIM*DATA_W-1:0] a_data,
  output logic                        wl_done,
  output logic                        fl_done,
  output logic                        weights_loaded,
  output logic                        busy,
  output logic                        start_err
);
  typedef enum logic [2:0] {IDLE, W_FETCH, W_DRAIN, F_FETCH, F_DRAIN} state_t;
  localparam logic [LEN_W-1:0] N1 = LEN_W'(ARRAY_DIM - 1);
  localparam logic [LEN_W-1:0] NN = LEN_W'(ARRAY_DIM);
  state_t state, nxt;
  logic [LEN_W-1:0] cnt, len;
  logic [ADDR_W-1:0] addr;
  logic [IW-1:0] widx;
  logic rd_w, rd_f, idle, accept_w, accept_f;
  always_comb begin
    idle = state == IDLE;
    accept_w = idle && wl_start;
    accept_f = idle && fl_start && !wl_start && weights_loaded && fl_len != '0;
    nxt = state;
    case (state)
      IDLE:    nxt = accept_w ? W_FETCH : accept_f ? F_FETCH : IDLE;
      W_FETCH: nxt = cnt == N1 ? W_DRAIN : W_FETCH;
      W_DRAIN: nxt = cnt == LEN_W'(1) ? IDLE : W_DRAIN;
      F_FETCH: nxt = cnt == len - LEN_W'(1) ? F_DRAIN : F_FETCH;
      F_DRAIN: nxt = cnt == NN ? IDLE : F_DRAIN;
      default: nxt = IDLE;
    endcase
  end
  assign mem_rd_en = state == W_FETCH || state == F_FETCH;
  assign mem_addr = mem_rd_en ? addr : '0;
  assign busy = !idle || w_row_valid || |a_valid;
  always_ff @(posedge clk) state <= !rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      len <= '0;
      addr <= '0;
      widx <= '0;
      rd_w <= 1'b0;
      rd_f <= 1'b0;
      w_row_valid <= 1'b0;
      w_row_idx <= '0;
      w_row_data <= '0;
      wl_done <= 1'b0;
      fl_done <= 1'b0;
      weights_loaded <= 1'b0;
      start_err <= 1'b0;
    end else begin
      cnt <= (idle || nxt != state) ? '0 : cnt + LEN_W'(1);
      len <= accept_f ? fl_len : len;
      addr <= accept_w ? weight_baseaddr : accept_f ? feature_baseaddr : mem_rd_en ? addr + ADDR_W'(1) : addr;
      rd_w <= state == W_FETCH;
      rd_f <= state == F_FETCH;
      w_row_valid <= rd_w;
      w_row_data <= rd_w ? mem_rd_data : '0;
      w_row_idx <= rd_w ? widx : '0;
      widx <= idle ? '0 : rd_w ? widx + IW'(1) : widx;
      wl_done <= state == W_DRAIN && nxt == IDLE;
      fl_done <= state == F_DRAIN && nxt == IDLE;
      weights_loaded <= accept_w ? 1'b0 : (state == W_DRAIN && nxt == IDLE) ? 1'b1 : weights_loaded;
      start_err <= idle ? fl_start && !accept_f : wl_start || fl_start;
    end
  end
  for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
    logic [DATA_W-1:0] sd [0:i];
    logic [i:0] sv;
    always_ff @(posedge clk) begin
      if (!rst) begin
        sv <= '0;
        for (int d = 0; d <= i; d++) sd[d] <= '0;
      end else begin
        sv[0] <= rd_f;
        sd[0] <= rd_f ? mem_rd_data[i*DATA_W +: DATA_W] : '0;
        for (int d = 1; d <= i; d++) begin
          sv[d] <= sv[d-1];
          sd[d] <= sd[d-1];
        end
      end
    end
    assign a_valid[i] = sv[i];
    assign a_data[i*DATA_W +: DATA_W] = sd[i];
  end
endmodule

// File: tb/tb_sa_operand_sequencer.sv
// tb_sa_operand_sequencer: event-schedule model check of the operand sequencer plus literal N=4 wrap check
module tb_sa_operand_sequencer;
  localparam int N = 2;
  localparam int MAXC = 256;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 0, wl_start = 0, fl_start = 0;
  logic [5:0] wb = 0, fb = 0;
  logic [7:0] fl_len = 0;
  logic mem_rd_en, w_row_valid, wl_done, fl_done, weights_loaded, busy, start_err;
  logic [5:0] mem_addr;
  logic [15:0] mem_rd_data, w_row_data, a_data;
  logic [0:0] w_row_idx;
  logic [1:0] a_valid;
  logic wl_start4 = 0, fl_start4 = 0;
  logic [5:0] wb4 = 0, fb4 = 0;
  logic [7:0] fl_len4 = 0;
  logic mem_rd_en4, w_row_valid4, wl_done4, fl_done4, wl4, busy4, err4;
  logic [5:0] mem_addr4;
  logic [31:0] rd4, w_row_data4, a_data4;
  logic [1:0] w_row_idx4;
  logic [3:0] a_valid4;
  sa_operand_sequencer #(.ARRAY_DIM(2), .DATA_W(8), .ADDR_W(6), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .wl_start(wl_start), .fl_start(fl_start),
    .weight_baseaddr(wb), .feature_baseaddr(fb), .fl_len(fl_len),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .w_row_valid(w_row_valid), .w_row_idx(w_row_idx), .w_row_data(w_row_data),
    .a_valid(a_valid), .a_data(a_data), .wl_done(wl_done), .fl_done(fl_done),
    .weights_loaded(weights_loaded), .busy(busy), .start_err(start_err));
  sa_operand_sequencer #(.ARRAY_DIM(4), .DATA_W(8), .ADDR_W(6), .LEN_W(8)) dut4 (
    .clk(clk), .rst(rst), .wl_start(wl_start4), .fl_start(fl_start4),
    .weight_baseaddr(wb4), .feature_baseaddr(fb4), .fl_len(fl_len4),
    .mem_rd_en(mem_rd_en4), .mem_addr(mem_addr4), .mem_rd_data(rd4),
    .w_row_valid(w_row_valid4), .w_row_idx(w_row_idx4), .w_row_data(w_row_data4),
    .a_valid(a_valid4), .a_data(a_data4), .wl_done(wl_done4), .fl_done(fl_done4),
    .weights_loaded(wl4), .busy(busy4), .start_err(err4));
  logic [15:0] mem [64];
  logic [31:0] mem4 [64];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    if (mem_rd_en4) rd4 <= mem4[mem_addr4];
  end
  bit e_rd [MAXC], e_wv [MAXC], e_wld [MAXC], e_fld [MAXC], e_wl [MAXC], e_busy [MAXC], e_err [MAXC];
  bit [5:0] e_addr [MAXC];
  bit [0:0] e_widx [MAXC];
  bit [15:0] e_wd [MAXC], e_ad [MAXC];
  bit [1:0] e_av [MAXC];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_fail = 0;
  bit cmp_on = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) if (cmp_on && cyc < MAXC) begin
    chk("mem_rd_en", mem_rd_en, e_rd[cyc]);
    chk("mem_addr", mem_addr, e_addr[cyc]);
    chk("w_row_valid", w_row_valid, e_wv[cyc]);
    chk("w_row_idx", w_row_idx, e_widx[cyc]);
    chk("w_row_data", w_row_data, e_wd[cyc]);
    chk("a_valid", a_valid, e_av[cyc]);
    chk("a_data", a_data, e_ad[cyc]);
    chk("wl_done", wl_done, e_wld[cyc]);
    chk("fl_done", fl_done, e_fld[cyc]);
    chk("weights_loaded", weights_loaded, e_wl[cyc]);
    chk("busy", busy, e_busy[cyc]);
    chk("start_err", start_err, e_err[cyc]);
  end
  task automatic sched_w(int c, bit [5:0] b);
    for (int j = 0; j < N; j++) begin
      bit [5:0] a = b + 6'(j);
      e_rd[c+1+j] = 1;
      e_addr[c+1+j] = a;
      e_wv[c+3+j] = 1;
      e_widx[c+3+j] = 1'(j);
      e_wd[c+3+j] = mem[a];
    end
    e_wld[c+N+3] = 1;
    for (int t = c + 1; t < MAXC; t++) e_wl[t] = t >= c + N + 3;
    for (int t = c + 1; t <= c + N + 2; t++) e_busy[t] = 1;
  endtask
  task automatic sched_f(int c, bit [5:0] b, int k);
    for (int v = 0; v < k; v++) begin
      bit [5:0] a = b + 6'(v);
      e_rd[c+1+v] = 1;
      e_addr[c+1+v] = a;
      for (int i = 0; i < N; i++) begin
        e_av[c+3+v+i][i] = 1;
        e_ad[c+3+v+i][i*8 +: 8] = mem[a][i*8 +: 8];
      end
    end
    e_fld[c+k+N+2] = 1;
    for (int t = c + 1; t <= c + k + N + 1; t++) e_busy[t] = 1;
  endtask
  task automatic reset_exp(int c);
    for (int t = c + 1; t < MAXC; t++) begin
      e_rd[t] = 0; e_addr[t] = 0; e_wv[t] = 0; e_widx[t] = 0; e_wd[t] = 0;
      e_av[t] = 0; e_ad[t] = 0; e_wld[t] = 0; e_fld[t] = 0; e_wl[t] = 0;
      e_busy[t] = 0; e_err[t] = 0;
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(int n);
    repeat (n) step();
  endtask
  task automatic do_start(bit w, bit f, bit [5:0] bw, bit [5:0] bf, bit [7:0] len);
    int c = cyc;
    if (!e_busy[c]) begin
      if (w) sched_w(c, bw);
      if (f && (w || !e_wl[c] || len == 0)) e_err[c+1] = 1;
      else if (f) sched_f(c, bf, int'(len));
    end else if (w || f) e_err[c+1] = 1;
    wl_start = w; fl_start = f; wb = bw; fb = bf; fl_len = len;
    step();
    wl_start = 0; fl_start = 0;
    wb = 6'($urandom); fb = 6'($urandom); fl_len = 8'($urandom);
  endtask
  logic [5:0] at4 [4];
  logic [31:0] dt4 [4];
  initial begin
    int c;
    for (int a = 0; a < 64; a++) begin
      mem[a] = {8'(a + 64), 8'(a + 128)};
      mem4[a] = 0;
    end
    mem[0] = 16'h0201; mem[1] = 16'h0403; mem[9] = 16'h0605; mem[10] = 16'h0807;
    mem4[62] = 32'h04030201; mem4[63] = 32'h08070605; mem4[0] = 32'h0c0b0a09; mem4[1] = 32'h100f0e0d;
    at4[0] = 62; at4[1] = 63; at4[2] = 0; at4[3] = 1;
    for (int t = 0; t < 4; t++) dt4[t] = mem4[at4[t]];
    step();
    cmp_on = 1;
    run(2);
    rst = 1;
    run(1);
    do_start(0, 1, 0, 9, 2);
    run(3);
    do_start(1, 0, 0, 0, 0);
    run(6);
    c = cyc;
    do_start(0, 1, 0, 9, 2);
    run(2);
    chk("lit lanes c3", {a_valid, a_data}, {2'b01, 16'h0005});
    step();
    chk("lit lanes c4", {a_valid, a_data}, {2'b11, 16'h0607});
    step();
    chk("lit lanes c5", {a_valid, a_data}, {2'b10, 16'h0800});
    step();
    chk("lit fl_done c6", {fl_done, busy}, 2'b10);
    run(2);
    do_start(0, 1, 0, 9, 0);
    run(3);
    do_start(1, 1, 0, 9, 2);
    run(6);
    do_start(0, 1, 0, 9, 2);
    run(1);
    do_start(1, 0, 20, 0, 0);
    do_start(0, 1, 0, 30, 4);
    run(6);
    do_start(1, 0, 10, 0, 0);
    run(4);
    do_start(0, 1, 0, 62, 3);
    run(8);
    do_start(1, 0, 63, 0, 0);
    run(4);
    do_start(1, 0, 5, 0, 0);
    run(7);
    do_start(0, 1, 0, 9, 3);
    step();
    rst = 0;
    reset_exp(cyc);
    step();
    rst = 1;
    chk("lit reset wl/busy/rd", {weights_loaded, busy, mem_rd_en, a_valid}, 0);
    run(6);
    do_start(0, 1, 0, 9, 2);
    run(3);
    cmp_on = 0;
    chk("n4 idle", {busy4, wl4}, 0);
    wb4 = 62;
    wl_start4 = 1;
    step();
    wl_start4 = 0;
    wb4 = 6'($urandom);
    for (int t = 1; t <= 7; t++) begin
      chk("n4 rd_en", mem_rd_en4, t <= 4);
      chk("n4 addr", mem_addr4, t <= 4 ? at4[(t-1)%4] : 6'd0);
      chk("n4 row_valid", w_row_valid4, t >= 3 && t <= 6);
      chk("n4 row_idx", w_row_idx4, (t >= 3 && t <= 6) ? 2'(t - 3) : 2'd0);
      chk("n4 row_data", w_row_data4, (t >= 3 && t <= 6) ? dt4[(t-3)%4] : 32'd0);
      chk("n4 wl_done", {wl_done4, wl4}, t == 7 ? 2'b11 : 2'b00);
      chk("n4 busy", busy4, t <= 6);
      chk("n4 idle lanes", {a_valid4, a_data4, fl_done4, err4}, 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
